ysyx_22041412_ifu: RTL and testbench
====================================

# ysyx_22041412_ifu

Instruction fetch unit directly upstream of the 4-way 16 KB instruction cache. It owns the PC, issues 16-byte line requests to the cache, and holds the returned 128-bit line in a one-entry line buffer. It hands 32-bit instructions to decode over a valid/ready handshake. It also handles redirects (branch/trap) by discarding in-flight cache reads, and sequences `fence.i` into the cache.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded on reset.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  one-cycle pulse from EXU: new PC.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (treated as 0).
- `fence_i_req`  in  1  one-cycle pulse: invalidate icache and line buffer.
- `fence_done`  out  1  one-cycle pulse when fence sequence completes.
- `icache_addr`  out  32  request address, always {pc[31:4],4'b0}.
- `icache_valid`  out  1  request valid, held until data or discard completes.
- `icache_data`  in  128  returned line.
- `icache_ready`  in  1  line valid on `icache_data`.
- `icache_read_vaild`  out  1  one-cycle acknowledge that the line was taken.
- `icache_read_clean`  out  1  discard request for the in-flight read.
- `icache_clear`  in  1  cache confirms the discard.
- `icache_fence_i`  out  1  one-cycle pulse to start cache invalidation.
- `icache_fence_ready`  in  1  cache invalidation finished.
- `inst_valid`  out  1  `inst`/`inst_pc` valid.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  address of `inst`.
- `inst_ready`  in  1  decode accepts.
- `fetch_cnt`  out  64  count of completed decode handshakes.

## Operation
- Registers: pc[31:0], line[127:0], line_tag[27:0], line_v, state.
- States: IDLE, REQ, SERVE, DISCARD, FENCE_WAIT, FENCE.
- Reset: pc=RESET_PC, line_v=0, state=IDLE, fetch_cnt=0. All outputs are 0 except `icache_addr`, which is {RESET_PC[31:4],0}.
- IDLE -> REQ unconditionally; it exists so the first request leaves reset cleanly.
- REQ: `icache_valid`=1. When `icache_ready`=1:
  - latch line, line_tag=pc[31:4], line_v=1;
  - drive `icache_read_vaild`=1 for that cycle;
  - `icache_valid` drops the next cycle; go to SERVE.
- SERVE: `inst_valid`=line_v & (line_tag==pc[31:4]); `inst`=line[pc[3:2]*32 +: 32]; `inst_pc`=pc.
  - On handshake: pc+=4 and fetch_cnt+=1.
  - If pc[3:2]==3 at the handshake: line_v=0 and go to REQ.
- Redirect (highest priority, every state except FENCE/FENCE_WAIT):
  - pc={redirect_pc[31:2],2'b0}.
  - A same-cycle decode handshake still counts; its pc+4 is overridden.
  - In REQ with no `icache_ready` this cycle: go to DISCARD.
  - In SERVE, or REQ completing this cycle: if line_v and the target is in the buffered line, stay in/enter SERVE with no refetch; else line_v=0 and go to REQ.
- DISCARD: `icache_valid`=1 and `icache_read_clean`=1 until `icache_clear`=1; then drop both and go to REQ with the new pc. A further redirect in DISCARD only updates pc.
- Fence: `fence_i_req` sets a sticky pending flag.
  - In SERVE or IDLE it is taken immediately.
  - In REQ it is taken after the current line completes; in DISCARD, after the discard completes.
  - Taken: line_v=0, go to FENCE_WAIT. `icache_valid` stays 0 in FENCE_WAIT and FENCE.
- FENCE_WAIT: pulse `icache_fence_i` one cycle; go to FENCE.
- FENCE: wait for `icache_fence_ready`; then pulse `fence_done`, clear the pending flag, go to REQ.
- Redirect during FENCE_WAIT/FENCE: latch pc only; no state change.
- pc wraps modulo 2^32; fetch_cnt wraps modulo 2^64.

## Timing
- All outputs are registered, except that `inst`/`inst_valid` are a mux of registers (no input-to-output combinational path).
- `icache_ready` at edge N: `inst_valid`=1 from cycle N+1. With `inst_ready` held 1, 4 instructions issue on consecutive cycles, then the next request is issued.
- Redirect at edge N: the new `icache_addr` is visible from N+1.
- `inst_valid` is never asserted for a pc whose line is not buffered. It drops the cycle after a redirect that misses the buffer.
- Asserting `rst_n` low mid-request clears state immediately. The cache is reset by the same reset net.

## Test plan
- Reset release, cache returns line 128'h..._00000013_00100093_00000293_00000513 at 0x80000000 -> `inst` sequence 0x00000513, 0x00000293, 0x00100093, 0x00000013 with pc 0x80000000..0x8000000C on 4 consecutive cycles; then `icache_addr`=0x80000010.
- Backpressure: `inst_ready`=0 for 5 cycles -> `inst`/`inst_pc` stable, `fetch_cnt` unchanged, no new cache request.
- Redirect to 0x80000008 while SERVE on line 0x80000000 -> next `inst_pc`=0x80000008 with no cache request. Redirect to 0x80001000 -> `icache_addr`=0x80001000 next cycle.
- Redirect to 0x80002000 while REQ is pending (cache miss) -> `icache_read_clean`=1 until `icache_clear`. No `inst_valid` for the old line. Then `icache_addr`=0x80002000.
- `fence_i_req` during REQ -> line completes; then `icache_fence_i` pulses once with `icache_valid`=0. After `icache_fence_ready`, `fence_done` pulses and the same pc is refetched.
- Simultaneous handshake and redirect at pc 0x8000000C -> `fetch_cnt`+1, next pc = redirect target, not 0x80000010.

Source files
------------

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: owns the PC, fetches 16-byte lines from the icache
// into a one-entry line buffer, serves 32-bit words to decode, and sequences
// redirects (discarding in-flight reads) and fence.i into the cache.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | one cycle after reset before the first request
// REQ        | line request outstanding, waiting for icache_ready
// SERVE      | line buffered, handing words to decode
// DISCARD    | redirected during a request, waiting for icache_clear
// FENCE_WAIT | pulse icache_fence_i for one cycle
// FENCE      | waiting for icache_fence_ready
module ysyx_22041412_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          fence_i_req,
    output logic          fence_done,
    output logic [31:0]   icache_addr,
    output logic          icache_valid,
    input  logic [127:0]  icache_data,
    input  logic          icache_ready,
    output logic          icache_read_vaild,
    output logic          icache_read_clean,
    input  logic          icache_clear,
    output logic          icache_fence_i,
    input  logic          icache_fence_ready,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    input  logic          inst_ready,
    output logic [63:0]   fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SERVE, S_DISCARD, S_FENCE_WAIT, S_FENCE
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [127:0]   line_q, line_d;
    logic [27:0]    tag_q, tag_d;
    logic           line_v_q, line_v_d;
    logic           fpend_q, fpend_d;
    logic           ack_q, ack_d;
    logic           fdone_q, fdone_d;
    logic [63:0]    cnt_q, cnt_d;
    logic [31:0]    ipc_q;
    logic [31:0]    redir_pc;
    logic           hs;
    logic           unused_redir_lsb;

    assign redir_pc         = {redirect_pc[31:2], 2'b00};
    assign unused_redir_lsb = ^redirect_pc[1:0];

    // Decode-side view: only a word of the buffered line matching pc is valid
    assign inst_valid = (state_q == S_SERVE) && line_v_q && (tag_q == pc_q[31:4]);
    assign hs         = inst_valid && inst_ready;

    // Word select out of the line buffer
    always_comb begin
        inst = line_q[31:0];
        case (pc_q[3:2])
            2'd0: inst = line_q[31:0];
            2'd1: inst = line_q[63:32];
            2'd2: inst = line_q[95:64];
            2'd3: inst = line_q[127:96];
            default: inst = line_q[31:0];
        endcase
    end

    assign inst_pc           = ipc_q;
    assign icache_addr       = {pc_q[31:4], 4'b0000};
    assign icache_valid      = (state_q == S_REQ) || (state_q == S_DISCARD);
    assign icache_read_clean = (state_q == S_DISCARD);
    assign icache_fence_i    = (state_q == S_FENCE_WAIT);
    assign icache_read_vaild = ack_q;
    assign fence_done        = fdone_q;
    assign fetch_cnt         = cnt_q;

    // Next-state, PC and line-buffer update
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        line_d   = line_q;
        tag_d    = tag_q;
        line_v_d = line_v_q;
        fpend_d  = fpend_q | fence_i_req;
        ack_d    = 1'b0;
        fdone_d  = 1'b0;
        cnt_d    = cnt_q + {63'd0, hs};

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) pc_d = redir_pc;
                if (fpend_d) begin
                    line_v_d = 1'b0;
                    state_d  = S_FENCE_WAIT;
                end
            end
            S_REQ: begin
                if (icache_ready) begin
                    line_d   = icache_data;
                    tag_d    = pc_q[31:4];
                    line_v_d = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = S_SERVE;
                    if (redirect_valid) begin
                        pc_d = redir_pc;
                        // the just-arrived line may already hold the target
                        if (redir_pc[31:4] != pc_q[31:4]) begin
                            line_v_d = 1'b0;
                            state_d  = S_REQ;
                        end
                    end
                    if (fpend_d) begin
                        line_v_d = 1'b0;
                        state_d  = S_FENCE_WAIT;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = S_DISCARD;
                end
            end
            S_SERVE: begin
                if (hs) begin
                    pc_d = pc_q + 32'd4;
                    if (pc_q[3:2] == 2'd3) begin
                        line_v_d = 1'b0;
                        state_d  = S_REQ;
                    end
                end
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (line_v_q && (tag_q == redir_pc[31:4])) begin
                        line_v_d = 1'b1;
                        state_d  = S_SERVE;
                    end else begin
                        line_v_d = 1'b0;
                        state_d  = S_REQ;
                    end
                end
                if (fpend_d) begin
                    line_v_d = 1'b0;
                    state_d  = S_FENCE_WAIT;
                end
            end
            S_DISCARD: begin
                if (redirect_valid) pc_d = redir_pc;
                if (icache_clear) begin
                    state_d = S_REQ;
                    if (fpend_d) begin
                        line_v_d = 1'b0;
                        state_d  = S_FENCE_WAIT;
                    end
                end
            end
            S_FENCE_WAIT: begin
                if (redirect_valid) pc_d = redir_pc;
                state_d = S_FENCE;
            end
            S_FENCE: begin
                if (redirect_valid) pc_d = redir_pc;
                if (icache_fence_ready) begin
                    fdone_d = 1'b1;
                    fpend_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            line_q   <= '0;
            tag_q    <= '0;
            line_v_q <= 1'b0;
            fpend_q  <= 1'b0;
            ack_q    <= 1'b0;
            fdone_q  <= 1'b0;
            cnt_q    <= '0;
            ipc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            line_q   <= line_d;
            tag_q    <= tag_d;
            line_v_q <= line_v_d;
            fpend_q  <= fpend_d;
            ack_q    <= ack_d;
            fdone_q  <= fdone_d;
            cnt_q    <= cnt_d;
            ipc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Directed, table-driven bench for the fetch unit with a simple icache model.
module tb_ysyx_22041412_ifu;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          fence_i_req;
    logic          fence_done;
    logic [31:0]   icache_addr;
    logic          icache_valid;
    logic [127:0]  icache_data;
    logic          icache_ready;
    logic          icache_read_vaild;
    logic          icache_read_clean;
    logic          icache_clear;
    logic          icache_fence_i;
    logic          icache_fence_ready;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_ready;
    logic [63:0]   fetch_cnt;

    int checks   = 0;
    int failures = 0;

    ysyx_22041412_ifu dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fence_i_req(fence_i_req), .fence_done(fence_done),
        .icache_addr(icache_addr), .icache_valid(icache_valid),
        .icache_data(icache_data), .icache_ready(icache_ready),
        .icache_read_vaild(icache_read_vaild), .icache_read_clean(icache_read_clean),
        .icache_clear(icache_clear), .icache_fence_i(icache_fence_i),
        .icache_fence_ready(icache_fence_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] p);
        return p ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        if (a == 32'h8000_0000)
            return {32'h0000_0013, 32'h0010_0093, 32'h0000_0293, 32'h0000_0513};
        return {w(a + 32'd12), w(a + 32'd8), w(a + 32'd4), w(a)};
    endfunction

    always_comb icache_data = line_of(icache_addr);

    typedef struct {
        logic        rdy, clr, frdy, irdy, rv, frq;
        logic [31:0] rpc;
        logic        e_val, e_clean, e_ack, e_fi, e_fd, e_iv;
        logic [31:0] e_addr, e_inst, e_ipc;
        logic [63:0] e_cnt;
    } vec_t;

    function automatic vec_t v(
        input logic rdy, clr, frdy, irdy, rv, input logic [31:0] rpc, input logic frq,
        input logic e_val, e_clean, e_ack, e_fi, e_fd, e_iv,
        input logic [31:0] e_addr, e_inst, e_ipc, input logic [63:0] e_cnt);
        vec_t r;
        r.rdy = rdy; r.clr = clr; r.frdy = frdy; r.irdy = irdy; r.rv = rv;
        r.rpc = rpc; r.frq = frq;
        r.e_val = e_val; r.e_clean = e_clean; r.e_ack = e_ack; r.e_fi = e_fi;
        r.e_fd = e_fd; r.e_iv = e_iv; r.e_addr = e_addr; r.e_inst = e_inst;
        r.e_ipc = e_ipc; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, clr, frdy, irdy, rv, input logic [31:0] rpc, input logic frq);
        icache_ready       = rdy;
        icache_clear       = clr;
        icache_fence_ready = frdy;
        inst_ready         = irdy;
        redirect_valid     = rv;
        redirect_pc        = rpc;
        fence_i_req        = frq;
    endtask

    vec_t vecs[30];

    initial begin
        localparam logic [31:0] B = 32'h8000_0000;
        //                 rdy clr frdy irdy rv rpc            frq | val cln ack fi fd iv addr          inst               ipc           cnt
        vecs[0]  = v(0,0,0,0,0, 32'h0,         0,  0,0,0,0,0,0, B,            32'h0,             32'h0,        0);
        vecs[1]  = v(1,0,0,0,0, 32'h0,         0,  1,0,0,0,0,0, B,            32'h0,             32'h0,        0);
        vecs[2]  = v(0,0,0,1,0, 32'h0,         0,  0,0,1,0,0,1, B,            32'h0000_0513,     B,            0);
        vecs[3]  = v(0,0,0,1,0, 32'h0,         0,  0,0,0,0,0,1, B,            32'h0000_0293,     B+4,          1);
        vecs[4]  = v(0,0,0,1,0, 32'h0,         0,  0,0,0,0,0,1, B,            32'h0010_0093,     B+8,          2);
        vecs[5]  = v(0,0,0,1,0, 32'h0,         0,  0,0,0,0,0,1, B,            32'h0000_0013,     B+12,         3);
        vecs[6]  = v(1,0,0,0,0, 32'h0,         0,  1,0,0,0,0,0, B+16,         32'h0,             32'h0,        4);
        vecs[7]  = v(0,0,0,0,0, 32'h0,         0,  0,0,1,0,0,1, B+16,         w(B+16),           B+16,         4);
        vecs[8]  = v(0,0,0,0,0, 32'h0,         0,  0,0,0,0,0,1, B+16,         w(B+16),           B+16,         4);
        vecs[9]  = v(0,0,0,0,0, 32'h0,         0,  0,0,0,0,0,1, B+16,         w(B+16),           B+16,         4);
        vecs[10] = v(0,0,0,0,0, 32'h0,         0,  0,0,0,0,0,1, B+16,         w(B+16),           B+16,         4);
        vecs[11] = v(0,0,0,0,0, 32'h0,         0,  0,0,0,0,0,1, B+16,         w(B+16),           B+16,         4);
        vecs[12] = v(0,0,0,1,0, 32'h0,         0,  0,0,0,0,0,1, B+16,         w(B+16),           B+16,         4);
        vecs[13] = v(0,0,0,0,1, 32'h8000_001B, 0,  0,0,0,0,0,1, B+16,         w(B+20),           B+20,         5);
        vecs[14] = v(0,0,0,1,1, 32'h8000_1000, 0,  0,0,0,0,0,1, B+16,         w(B+24),           B+24,         5);
        vecs[15] = v(0,0,0,0,0, 32'h0,         0,  1,0,0,0,0,0, 32'h8000_1000, 32'h0,            32'h0,        6);
        vecs[16] = v(0,0,0,0,1, 32'h8000_2000, 0,  1,0,0,0,0,0, 32'h8000_1000, 32'h0,            32'h0,        6);
        vecs[17] = v(0,0,0,0,0, 32'h0,         0,  1,1,0,0,0,0, 32'h8000_2000, 32'h0,            32'h0,        6);
        vecs[18] = v(0,1,0,0,0, 32'h0,         0,  1,1,0,0,0,0, 32'h8000_2000, 32'h0,            32'h0,        6);
        vecs[19] = v(0,0,0,0,0, 32'h0,         1,  1,0,0,0,0,0, 32'h8000_2000, 32'h0,            32'h0,        6);
        vecs[20] = v(1,0,0,0,0, 32'h0,         0,  1,0,0,0,0,0, 32'h8000_2000, 32'h0,            32'h0,        6);
        vecs[21] = v(0,0,0,0,0, 32'h0,         0,  0,0,1,1,0,0, 32'h8000_2000, 32'h0,            32'h0,        6);
        vecs[22] = v(0,0,0,0,0, 32'h0,         0,  0,0,0,0,0,0, 32'h8000_2000, 32'h0,            32'h0,        6);
        vecs[23] = v(0,0,1,0,0, 32'h0,         0,  0,0,0,0,0,0, 32'h8000_2000, 32'h0,            32'h0,        6);
        vecs[24] = v(1,0,0,0,0, 32'h0,         0,  1,0,0,0,1,0, 32'h8000_2000, 32'h0,            32'h0,        6);
        vecs[25] = v(0,0,0,1,0, 32'h0,         0,  0,0,1,0,0,1, 32'h8000_2000, w(32'h8000_2000), 32'h8000_2000, 6);
        vecs[26] = v(0,0,0,1,0, 32'h0,         0,  0,0,0,0,0,1, 32'h8000_2000, w(32'h8000_2004), 32'h8000_2004, 7);
        vecs[27] = v(0,0,0,1,0, 32'h0,         0,  0,0,0,0,0,1, 32'h8000_2000, w(32'h8000_2008), 32'h8000_2008, 8);
        vecs[28] = v(0,0,0,1,1, 32'h8000_0100, 0,  0,0,0,0,0,1, 32'h8000_2000, w(32'h8000_200C), 32'h8000_200C, 9);
        vecs[29] = v(0,0,0,0,0, 32'h0,         0,  1,0,0,0,0,0, 32'h8000_0100, 32'h0,            32'h0,        10);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        repeat (2) @(negedge clk);
        chk("rst_icache_addr", {32'h0, icache_addr}, {32'h0, B});
        chk("rst_icache_valid", {63'h0, icache_valid}, 64'h0);
        chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst_inst", {32'h0, inst}, 64'h0);
        chk("rst_inst_pc", {32'h0, inst_pc}, 64'h0);
        chk("rst_fetch_cnt", fetch_cnt, 64'h0);
        chk("rst_fence_i", {63'h0, icache_fence_i}, 64'h0);
        chk("rst_read_ack", {63'h0, icache_read_vaild}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i].rdy, vecs[i].clr, vecs[i].frdy, vecs[i].irdy,
                  vecs[i].rv, vecs[i].rpc, vecs[i].frq);
            #1;
            chk($sformatf("v%0d_icache_valid", i), {63'h0, icache_valid}, {63'h0, vecs[i].e_val});
            chk($sformatf("v%0d_read_clean", i), {63'h0, icache_read_clean}, {63'h0, vecs[i].e_clean});
            chk($sformatf("v%0d_read_ack", i), {63'h0, icache_read_vaild}, {63'h0, vecs[i].e_ack});
            chk($sformatf("v%0d_fence_i", i), {63'h0, icache_fence_i}, {63'h0, vecs[i].e_fi});
            chk($sformatf("v%0d_fence_done", i), {63'h0, fence_done}, {63'h0, vecs[i].e_fd});
            chk($sformatf("v%0d_inst_valid", i), {63'h0, inst_valid}, {63'h0, vecs[i].e_iv});
            chk($sformatf("v%0d_icache_addr", i), {32'h0, icache_addr}, {32'h0, vecs[i].e_addr});
            chk($sformatf("v%0d_fetch_cnt", i), fetch_cnt, vecs[i].e_cnt);
            if (vecs[i].e_iv) begin
                chk($sformatf("v%0d_inst", i), {32'h0, inst}, {32'h0, vecs[i].e_inst});
                chk($sformatf("v%0d_inst_pc", i), {32'h0, inst_pc}, {32'h0, vecs[i].e_ipc});
            end
            @(negedge clk);
        end

        // PC wrap: redirect to the last word of the address space, fetch it, step to 0
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        #1 chk("wrap_req_valid", {63'h0, icache_valid}, 64'h1);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 32'h0, 0);
        #1 chk("wrap_discard_clean", {63'h0, icache_read_clean}, 64'h1);
        chk("wrap_discard_addr", {32'h0, icache_addr}, 64'h0000_0000_FFFF_FFF0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'h0, 0);
        #1 chk("wrap_req_clean", {63'h0, icache_read_clean}, 64'h0);
        chk("wrap_req_valid2", {63'h0, icache_valid}, 64'h1);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 32'h0, 0);
        #1 chk("wrap_serve_iv", {63'h0, inst_valid}, 64'h1);
        chk("wrap_serve_pc", {32'h0, inst_pc}, 64'h0000_0000_FFFF_FFFC);
        chk("wrap_serve_inst", {32'h0, inst}, {32'h0, w(32'hFFFF_FFFC)});
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        #1 chk("wrap_next_addr", {32'h0, icache_addr}, 64'h0);
        chk("wrap_next_iv", {63'h0, inst_valid}, 64'h0);
        chk("wrap_cnt", fetch_cnt, 64'd11);
        chk("wrap_next_valid", {63'h0, icache_valid}, 64'h1);

        // Async reset in the middle of an outstanding request
        #2 rst_n = 1'b0;
        #1 chk("arst_valid", {63'h0, icache_valid}, 64'h0);
        chk("arst_addr", {32'h0, icache_addr}, {32'h0, B});
        chk("arst_cnt", fetch_cnt, 64'h0);
        chk("arst_inst_pc", {32'h0, inst_pc}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
